// File: rtl/dk_arb_pkg.sv
// Shared types for the Donkey Kong work-RAM arbiter: FSM state encoding
// and the drain counter width.
package dk_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBL,
    DRAIN,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam int DRAIN_W = 4;

endpackage

// File: rtl/dk_pause_ctl.sv
// User pause handling: button edge detect, pause toggle and the saturating
// idle counter that dims the video after a long user pause.
module dk_pause_ctl #(
  parameter logic [31:0] DIM_CYCLES = 32'd240000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pause_btn,
  output logic pause_next,
  output logic user_pause,
  output logic dim_video
);

  logic        btn_q;
  logic [31:0] dim_cnt;

  // Next toggle value is exported so the top can register cpu_pause in the same cycle.
  assign pause_next = user_pause ^ (pause_btn & ~btn_q);
  assign dim_video  = (dim_cnt >= DIM_CYCLES);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_q      <= 1'b0;
      user_pause <= 1'b0;
      dim_cnt    <= '0;
    end else begin
      btn_q      <= pause_btn;
      user_pause <= pause_next;
      if (user_pause) begin
        if (dim_cnt < DIM_CYCLES)
          dim_cnt <= dim_cnt + 32'd1;
      end else begin
        dim_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dk_ram_arbiter.sv
// Shares the main-CPU work RAM between the Z80 and the hiscore engine,
// owning the CPU pause line and the video-dim flag.
module dk_ram_arbiter
  import dk_arb_pkg::*;
#(
  parameter int          AW         = 16,
  parameter int          DW         = 8,
  parameter int          DRAIN_CYC  = 4,
  parameter logic [31:0] DIM_CYCLES = 32'd240000000,
  parameter int          VBL_SYNC   = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vblank,
  input  logic          pause_btn,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic          hs_we,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          cpu_pause,
  output logic          dim_video
);

  arb_state_t         state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               vbl_q;
  logic               vbl_rise;
  logic               hs_ack_q;
  logic [DW-1:0]      hs_hold;
  logic               pause_next;
  logic               user_pause;

  function automatic logic fsm_holds_cpu(input arb_state_t s);
    return (s == DRAIN) || (s == GRANT) || (s == RELEASE);
  endfunction

  dk_pause_ctl #(
    .DIM_CYCLES (DIM_CYCLES)
  ) u_pause_ctl (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pause_btn  (pause_btn),
    .pause_next (pause_next),
    .user_pause (user_pause),
    .dim_video  (dim_video)
  );

  assign vbl_rise = vblank & ~vbl_q;

  // IDLE deliberately ignores vbl_rise, so an edge coincident with the request is skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (hs_req) state_nxt = (VBL_SYNC != 0) ? WAIT_VBL : DRAIN;
      WAIT_VBL: if (!hs_req) state_nxt = IDLE;
                else if (vbl_rise) state_nxt = DRAIN;
      DRAIN:    if (!hs_req) state_nxt = RELEASE;
                else if (drain_cnt == '0) state_nxt = GRANT;
      GRANT:    if (!hs_req) state_nxt = RELEASE;
      RELEASE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      vbl_q     <= 1'b0;
      hs_ack    <= 1'b0;
      hs_ack_q  <= 1'b0;
      cpu_pause <= 1'b0;
      hs_hold   <= '0;
    end else begin
      state     <= state_nxt;
      vbl_q     <= vblank;
      hs_ack    <= (state_nxt == GRANT);
      hs_ack_q  <= hs_ack;
      cpu_pause <= pause_next | fsm_holds_cpu(state_nxt);
      hs_hold   <= hs_rdata;
      if (state_nxt == DRAIN && state != DRAIN)
        drain_cnt <= DRAIN_W'(DRAIN_CYC);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  // Read data lags the address by one cycle, so hiscore capture follows the delayed grant.
  assign hs_rdata  = hs_ack_q ? ram_rdata : hs_hold;
  assign cpu_rdata = ram_rdata;

  assign ram_addr  = hs_ack ? hs_addr  : cpu_addr;
  assign ram_wdata = hs_ack ? hs_wdata : cpu_wdata;
  assign ram_we    = hs_ack ? hs_we    : (cpu_we & ~cpu_pause);

endmodule

// File: tb/tb_dk_ram_arbiter.sv
// Scoreboard bench for dk_ram_arbiter: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dk_ram_arbiter;

  localparam int S_PAUSE   = 0;
  localparam int S_ACK     = 1;
  localparam int S_DIM     = 2;
  localparam int S_WE      = 3;
  localparam int S_ADDR    = 4;
  localparam int S_HSRD    = 5;
  localparam int S_WDATA   = 6;
  localparam int S_CPURD   = 7;
  localparam int S_ACKSEEN = 8;
  localparam int S_DIMSEEN = 9;

  logic        clk_sys = 1'b0;
  logic        reset, vblank, pause_btn;
  logic [15:0] cpu_addr, hs_addr, ram_addr;
  logic        cpu_we, hs_we, hs_req, hs_ack, ram_we, cpu_pause, dim_video;
  logic [7:0]  cpu_wdata, cpu_rdata, hs_wdata, hs_rdata, ram_wdata, ram_rdata;

  always #5 clk_sys = ~clk_sys;

  dk_ram_arbiter #(
    .DIM_CYCLES (32'd100)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vblank    (vblank),
    .pause_btn (pause_btn),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .hs_req    (hs_req),
    .hs_addr   (hs_addr),
    .hs_we     (hs_we),
    .hs_wdata  (hs_wdata),
    .hs_rdata  (hs_rdata),
    .hs_ack    (hs_ack),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cpu_pause (cpu_pause),
    .dim_video (dim_video)
  );

  // Synchronous RAM model, one-cycle read latency
  logic [7:0] mem [0:255];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    int          base;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_cnt = 0;
  int   dim_seen = 0;
  logic flush = 1'b0;

  function automatic logic [31:0] observe(input int sig, input int base);
    case (sig)
      S_PAUSE:   return {31'd0, cpu_pause};
      S_ACK:     return {31'd0, hs_ack};
      S_DIM:     return {31'd0, dim_video};
      S_WE:      return {31'd0, ram_we};
      S_ADDR:    return {16'd0, ram_addr};
      S_HSRD:    return {24'd0, hs_rdata};
      S_WDATA:   return {24'd0, ram_wdata};
      S_CPURD:   return {24'd0, cpu_rdata};
      S_ACKSEEN: return 32'(ack_cnt - base);
      S_DIMSEEN: return 32'(dim_seen - base);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int dc, input int sig, input logic [31:0] val, input string name);
    exp_t e;
    int   i;
    e.cyc  = cyc + dc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    e.base = (sig == S_ACKSEEN) ? ack_cnt : (sig == S_DIMSEEN) ? dim_seen : 0;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin
    exp_t        e;
    logic [31:0] act;
    if (hs_ack) ack_cnt++;
    if (dim_video) dim_seen++;
    while (q.size() > 0 && (flush || q[0].cyc <= cyc)) begin
      e = q.pop_front();
      vectors++;
      act = observe(e.sig, e.base);
      if (e.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: not checked on time (due cycle %0d, now %0d), got %0h required %0h",
                 e.name, e.cyc, cyc, act, e.val);
      end else if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %0h required %0h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vblank = 1'b0; pause_btn = 1'b0;
    cpu_addr = 16'h0042; cpu_we = 1'b0; cpu_wdata = 8'h00;
    hs_req = 1'b0; hs_addr = 16'h0000; hs_we = 1'b0; hs_wdata = 8'h00;
    tick(2);
    expect_at(0, S_ACK,   0, "rst_hs_ack");
    expect_at(0, S_PAUSE, 0, "rst_cpu_pause");
    expect_at(0, S_DIM,   0, "rst_dim_video");
    expect_at(0, S_HSRD,  0, "rst_hs_rdata");
    expect_at(0, S_ADDR,  32'h0042, "rst_ram_addr_cpu");
    tick(1);
    reset = 1'b0;
    tick(1);

    // User pause press / release, CPU write suppression
    pause_btn = 1'b1;
    expect_at(0,  S_PAUSE, 0, "pause_before_edge");
    expect_at(1,  S_PAUSE, 1, "pause_on");
    expect_at(3,  S_PAUSE, 1, "pause_held_level");
    expect_at(12, S_DIMSEEN, 0, "short_pause_no_dim");
    tick(3);
    pause_btn = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h11;
    expect_at(0, S_WE,   0, "paused_cpu_we_blocked");
    expect_at(0, S_ADDR, 32'h0010, "paused_ram_addr_cpu");
    tick(2);
    cpu_we = 1'b0; pause_btn = 1'b1;
    expect_at(1, S_PAUSE, 0, "pause_off");
    tick(1);
    pause_btn = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'hA5;
    expect_at(0, S_WE, 1, "unpaused_cpu_we");
    tick(1);
    cpu_we = 1'b0;
    expect_at(1, S_CPURD, 32'hA5, "cpu_readback");
    tick(6);

    // Long user pause dims the video after exactly 100 cycles
    pause_btn = 1'b1;
    expect_at(1,   S_PAUSE, 1, "dim_pause_on");
    expect_at(100, S_DIM,   0, "dim_not_early");
    expect_at(101, S_DIM,   1, "dim_on_time");
    expect_at(150, S_DIM,   1, "dim_saturated");
    tick(1);
    pause_btn = 1'b0;
    tick(159);
    pause_btn = 1'b1;
    expect_at(1, S_PAUSE, 0, "undim_pause_off");
    expect_at(1, S_DIM,   1, "dim_still_on");
    expect_at(2, S_DIM,   0, "dim_cleared");
    tick(1);
    pause_btn = 1'b0;
    tick(3);

    // Request coincides with a vblank edge: that edge is skipped
    hs_req = 1'b1; vblank = 1'b1;
    expect_at(1, S_PAUSE, 0, "coincident_edge_skipped1");
    expect_at(2, S_PAUSE, 0, "coincident_edge_skipped2");
    tick(2);
    vblank = 1'b0;
    tick(2);
    vblank = 1'b1;
    expect_at(0, S_PAUSE, 0, "wait_vbl_no_pause");
    expect_at(1, S_PAUSE, 1, "drain_pause");
    expect_at(5, S_ACK,   0, "ack_not_early");
    expect_at(6, S_ACK,   1, "ack_on_time");
    tick(6);
    vblank = 1'b0;

    // Hiscore write and readback during GRANT
    hs_we = 1'b1; hs_addr = 16'h6100; hs_wdata = 8'h5A;
    cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h33;
    expect_at(0, S_WE,    1, "hs_write_we");
    expect_at(0, S_ADDR,  32'h6100, "hs_write_addr");
    expect_at(0, S_WDATA, 32'h5A, "hs_write_data");
    expect_at(1, S_ACK,   1, "grant_past_vblank");
    expect_at(1, S_PAUSE, 1, "grant_cpu_paused");
    tick(1);
    hs_we = 1'b0;
    expect_at(0, S_WE,   0, "grant_cpu_we_ignored");
    expect_at(1, S_HSRD, 32'h5A, "hs_readback");
    tick(1);
    hs_req = 1'b0;
    expect_at(1, S_ACK,   0, "release_ack_low");
    expect_at(1, S_PAUSE, 1, "release_pause");
    expect_at(1, S_ADDR,  32'h0020, "release_mux_cpu");
    expect_at(2, S_PAUSE, 0, "idle_unpause");
    expect_at(2, S_WE,    1, "cpu_we_resumes");
    expect_at(3, S_HSRD,  32'h5A, "hs_rdata_hold");
    tick(3);
    cpu_we = 1'b0;
    expect_at(1, S_CPURD, 32'h33, "cpu_write_after_release");
    tick(3);

    // Request dropped during DRAIN: no grant
    hs_req = 1'b1; vblank = 1'b0;
    expect_at(8, S_ACKSEEN, 0, "drain_abort_no_ack");
    tick(2);
    vblank = 1'b1;
    expect_at(1, S_PAUSE, 1, "drain2_pause");
    tick(2);
    hs_req = 1'b0;
    expect_at(0, S_ACK,   0, "drain_abort_ack0");
    expect_at(1, S_PAUSE, 1, "drain_abort_release");
    expect_at(2, S_PAUSE, 0, "drain_abort_idle");
    tick(4);

    // Reset in the middle of GRANT, then restart from WAIT_VBL
    vblank = 1'b0; hs_req = 1'b1;
    tick(2);
    vblank = 1'b1;
    expect_at(6, S_ACK, 1, "ack_again");
    tick(8);
    cpu_addr = 16'h0077; hs_addr = 16'h6100; reset = 1'b1;
    expect_at(0, S_ACK,   0, "rst_mid_grant_ack");
    expect_at(0, S_PAUSE, 0, "rst_mid_grant_pause");
    expect_at(0, S_ADDR,  32'h0077, "rst_mid_grant_mux");
    tick(1);
    reset = 1'b0;
    expect_at(1, S_PAUSE, 0, "restart_wait1");
    expect_at(3, S_PAUSE, 0, "restart_wait3");
    tick(3);
    vblank = 1'b0;
    tick(1);
    vblank = 1'b1;
    expect_at(1, S_PAUSE, 1, "restart_drain");
    expect_at(5, S_ACK,   0, "restart_ack_not_early");
    expect_at(6, S_ACK,   1, "restart_ack");
    tick(7);
    hs_req = 1'b0;
    tick(4);

    flush = 1'b1;
    @(negedge clk_sys);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
